// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Bridges a valid/ready core load/store request channel onto a simple
//   single-port word memory with per-byte write strobes and a one-cycle
//   registered read. Handles RISC-V byte/half/word widths, sign/zero extension
//   of loads, byte-lane replication of store data, and fault detection
//   (misalignment, out-of-range address, illegal funct3).
//
// Ports
//   clk, reset                : clock, synchronous active-high reset
//   req_valid/req_ready       : request handshake
//   req_write, req_funct3     : store(1)/load(0), RISC-V width code
//   req_addr, req_wdata       : byte address, right-aligned store data
//   rsp_valid/rsp_ready       : response handshake
//   rsp_rdata, rsp_fault      : extended load data (0 on store/fault), fault flag
//   mem_address               : memory byte address (valid during ISSUE)
//   mem_write_data            : lane-replicated store data
//   mem_write_enable          : per-byte strobes, bit i covers bits [8i+7:8i]
//   mem_read_data             : read data, one cycle after address is sampled
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_enable,
    input  logic [31:0] mem_read_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]  state_reg, state_next;
    logic [31:0] addr_reg;
    logic [2:0]  funct3_reg;
    logic        write_reg;
    logic [31:0] wdata_reg;
    logic        fault_reg;
    logic [31:0] rdata_reg;

    logic        accept;
    logic        req_fault;
    logic [31:0] load_value;
    logic [3:0]  lane_strobe;
    logic [31:0] lane_data;
    logic        issue_store;

    assign req_ready = (state_reg == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // Fault classification of the incoming request, decided at acceptance.
    always_comb begin
        req_fault = 1'b0;
        case (req_funct3)
            3'd0:    req_fault = 1'b0;
            3'd1:    req_fault = req_addr[0];
            3'd2:    req_fault = (req_addr[1:0] != 2'b00);
            3'd4:    req_fault = req_write;
            3'd5:    req_fault = req_write || req_addr[0];
            default: req_fault = 1'b1;
        endcase
        if (req_addr[31:2] >= 30'(SIZE)) begin
            req_fault = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = req_fault ? RESP : ISSUE;
            ISSUE:   state_next = write_reg ? RESP : WAIT;
            WAIT:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Load extraction: byte/half lanes are picked from the word using the low
    // address bits; funct3[2] distinguishes unsigned variants.
    always_comb begin
        logic [7:0]  load_byte;
        logic [15:0] load_half;
        load_byte = mem_read_data[{addr_reg[1:0], 3'b000} +: 8];
        load_half = mem_read_data[{addr_reg[1], 4'b0000} +: 16];
        case (funct3_reg[1:0])
            2'd0:    load_value = funct3_reg[2] ? {24'd0, load_byte}
                                                : {{24{load_byte[7]}}, load_byte};
            2'd1:    load_value = funct3_reg[2] ? {16'd0, load_half}
                                                : {{16{load_half[15]}}, load_half};
            default: load_value = mem_read_data;
        endcase
    end

    // Per-lane store strobe and data. Stores reaching ISSUE are already
    // known to be aligned, so a halfword strobe is simply the half selected
    // by addr[1], and the data lanes are the replicated byte/half.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_strobe[gi] =
                (funct3_reg[1:0] == 2'd0) ? (addr_reg[1:0] == 2'(gi)) :
                (funct3_reg[1:0] == 2'd1) ? (addr_reg[1] == 1'(gi / 2)) :
                                            1'b1;
            assign lane_data[8*gi +: 8] =
                (funct3_reg[1:0] == 2'd0) ? wdata_reg[7:0] :
                (funct3_reg[1:0] == 2'd1) ? wdata_reg[8*(gi % 2) +: 8] :
                                            wdata_reg[8*gi +: 8];
        end
    endgenerate

    // Reset gates the strobes combinationally so a reset arriving mid-ISSUE
    // never lets a write slip through on that edge.
    assign issue_store      = (state_reg == ISSUE) && write_reg && !reset;
    assign mem_write_enable = issue_store ? lane_strobe : 4'b0000;
    assign mem_write_data   = issue_store ? lane_data : 32'd0;
    assign mem_address      = (state_reg == ISSUE) ? addr_reg : 32'd0;

    assign rsp_valid = (state_reg == RESP);
    assign rsp_rdata = (state_reg == RESP) ? rdata_reg : 32'd0;
    assign rsp_fault = (state_reg == RESP) && fault_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            addr_reg   <= 32'd0;
            funct3_reg <= 3'd0;
            write_reg  <= 1'b0;
            wdata_reg  <= 32'd0;
            fault_reg  <= 1'b0;
            rdata_reg  <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg   <= req_addr;
                funct3_reg <= req_funct3;
                write_reg  <= req_write;
                wdata_reg  <= req_wdata;
                fault_reg  <= req_fault;
                rdata_reg  <= 32'd0;
            end
            if (state_reg == WAIT) begin
                rdata_reg <= load_value;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_enable;
    logic [31:0] mem_read_data;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:1023];
    logic [3:0]  first_we;
    logic [31:0] first_wd;
    logic [31:0] first_addr;

    always #5 clk = ~clk;

    load_store_unit #(.SIZE(1024)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_fault(rsp_fault),
        .mem_address(mem_address),
        .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable),
        .mem_read_data(mem_read_data)
    );

    // Byte-strobed memory with registered read.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_write_enable[i]) mem[mem_address[11:2]][8*i +: 8] <= mem_write_data[8*i +: 8];
        end
        mem_read_data <= mem[mem_address[11:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transaction: present at a negedge, check latency, response
    // contents, write-strobe behaviour, and release on rsp_ready.
    task automatic do_req(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rd,
                          input logic exp_fault);
        int lat;
        logic [3:0] we_or;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        lat = 1;
        we_or = 4'b0000;
        first_we = mem_write_enable;
        first_wd = mem_write_data;
        first_addr = mem_address;
        while (!rsp_valid && lat < 8) begin
            we_or |= mem_write_enable;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, rsp_rdata, exp_rd);
        check({tag, "_fault"}, 32'(rsp_fault), 32'(exp_fault));
        if (exp_fault || !w) check({tag, "_no_write"}, 32'(we_or), 32'd0);
        $display("txn %s: write=%0b funct3=%0d addr=0x%08h lat=%0d rdata=0x%08h fault=%0b",
                 tag, w, f3, a, lat, rsp_rdata, rsp_fault);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
        mem[4]    = 32'h80FF7F01;
        mem[1023] = 32'h12345678;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_we", 32'(mem_write_enable), 32'd0);
        check("rst_addr", mem_address, 32'd0);
        reset = 1'b0;

        // Loads of the preloaded word
        do_req("lb_13",  1'b0, 3'd0, 32'h13, 32'd0, 3, 32'hFFFFFF80, 1'b0);
        do_req("lhu_12", 1'b0, 3'd5, 32'h12, 32'd0, 3, 32'h000080FF, 1'b0);
        do_req("lh_12",  1'b0, 3'd1, 32'h12, 32'd0, 3, 32'hFFFF80FF, 1'b0);
        do_req("lw_10",  1'b0, 3'd2, 32'h10, 32'd0, 3, 32'h80FF7F01, 1'b0);
        do_req("lbu_11", 1'b0, 3'd4, 32'h11, 32'd0, 3, 32'h0000007F, 1'b0);

        // Byte store into lane 1
        do_req("sb_11", 1'b1, 3'd0, 32'h11, 32'h000000A5, 2, 32'd0, 1'b0);
        check("sb_11_we", 32'(first_we), 32'h2);
        check("sb_11_wd", first_wd, 32'hA5A5A5A5);
        check("sb_11_addr", first_addr, 32'h11);
        do_req("lw_after_sb", 1'b0, 3'd2, 32'h10, 32'd0, 3, 32'h80FFA501, 1'b0);

        // Halfword store into upper half
        do_req("sh_12", 1'b1, 3'd1, 32'h12, 32'h00001234, 2, 32'd0, 1'b0);
        check("sh_12_we", 32'(first_we), 32'hC);
        check("sh_12_wd", first_wd, 32'h12341234);
        do_req("lw_after_sh", 1'b0, 3'd2, 32'h10, 32'd0, 3, 32'h1234A501, 1'b0);

        // Faults
        do_req("f_lw_12",   1'b0, 3'd2, 32'h12,   32'd0, 1, 32'd0, 1'b1);
        do_req("f_sh_13",   1'b1, 3'd1, 32'h13,   32'hFFFF, 1, 32'd0, 1'b1);
        do_req("f_ld_f3_3", 1'b0, 3'd3, 32'h10,   32'd0, 1, 32'd0, 1'b1);
        do_req("f_lw_1000", 1'b0, 3'd2, 32'h1000, 32'd0, 1, 32'd0, 1'b1);
        do_req("f_sw_f3_4", 1'b1, 3'd4, 32'h10,   32'd0, 1, 32'd0, 1'b1);
        check("fault_mem_intact", mem[4], 32'h1234A501);

        // Last in-range word
        do_req("lw_ffc", 1'b0, 3'd2, 32'hFFC, 32'd0, 3, 32'h12345678, 1'b0);

        // Response held while rsp_ready is low; competing request ignored
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        check("stall_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_rdata", rsp_rdata, 32'h1234A501);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_we", 32'(mem_write_enable), 32'd0);
            @(negedge clk);
        end
        check("stall_valid_end", 32'(rsp_valid), 32'd1);
        $display("txn stall_lw_10: rdata=0x%08h held 5 cycles", rsp_rdata);
        rsp_ready = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("stall_drop", 32'(rsp_valid), 32'd0);
        check("stall_idle_ready", 32'(req_ready), 32'd1);
        check("stall_mem_intact", mem[4], 32'h1234A501);

        // Reset while a store is in ISSUE
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
        check("rst_sw_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_issue_we", 32'(mem_write_enable), 32'd0);
        @(negedge clk);
        check("rst_after_valid", 32'(rsp_valid), 32'd0);
        check("rst_after_fault", 32'(rsp_fault), 32'd0);
        check("rst_after_rdata", rsp_rdata, 32'd0);
        check("rst_after_addr", mem_address, 32'd0);
        check("rst_after_wd", mem_write_data, 32'd0);
        check("rst_after_we", 32'(mem_write_enable), 32'd0);
        check("rst_after_ready", 32'(req_ready), 32'd0);
        check("rst_mem_intact", mem[4], 32'h1234A501);
        $display("txn sw_reset_abort: mem[4]=0x%08h", mem[4]);
        reset = 1'b0;
        do_req("lw_after_rst", 1'b0, 3'd2, 32'h10, 32'd0, 3, 32'h1234A501, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
